// File: rtl/gpio_in_conditioner.sv
// gpio_in_conditioner
// Conditions raw asynchronous pad inputs for the GPIO peripheral: a
// per-pin synchronizer chain, an optional per-pin debounce filter, and
// edge detection feeding sticky interrupt-pending flags.

module gpio_in_conditioner #(
  parameter int NUM_PINS        = 26,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NUM_PINS-1:0] pad_i,
  input  logic [NUM_PINS-1:0] deb_en_i,
  input  logic [NUM_PINS-1:0] rise_en_i,
  input  logic [NUM_PINS-1:0] fall_en_i,
  input  logic [NUM_PINS-1:0] irq_clr_i,
  output logic [NUM_PINS-1:0] gpio_dat_o,
  output logic [NUM_PINS-1:0] irq_pend_o,
  output logic                irq_o
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_PINS-1:0] sync_q [SYNC_STAGES];
  logic [NUM_PINS-1:0] s;

  logic [NUM_PINS-1:0] stable_q;
  logic [NUM_PINS-1:0] stable_d;
  logic [CNT_W-1:0]    cnt_q [NUM_PINS];
  logic [CNT_W-1:0]    cnt_d [NUM_PINS];

  logic [NUM_PINS-1:0] rise;
  logic [NUM_PINS-1:0] fall;
  logic [NUM_PINS-1:0] pend_q;
  logic [NUM_PINS-1:0] pend_d;

  // Plain flop chain per pin; nothing sits between stages so the chain
  // only resolves metastability.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
    end else begin
      sync_q[0] <= pad_i;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Debounce next-state: bypassed pins follow the synchronizer directly;
  // debounced pins only change after DEBOUNCE_CYCLES consecutive differing
  // samples, and any agreeing sample restarts the count.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < NUM_PINS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (!deb_en_i[i]) begin
        stable_d[i] = s[i];
        cnt_d[i]    = '0;
      end else if (s[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        stable_d[i] = s[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Conditioned value and debounce counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stable_q <= '0;
      for (int i = 0; i < NUM_PINS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      stable_q <= stable_d;
      for (int i = 0; i < NUM_PINS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Edges are taken on the same edge the conditioned value changes, with
  // the enables sampled on that edge; a new edge beats a same-cycle clear.
  always_comb begin
    rise   = stable_d & ~stable_q & rise_en_i;
    fall   = ~stable_d & stable_q & fall_en_i;
    pend_d = (pend_q & ~irq_clr_i) | rise | fall;
  end

  // Sticky pending flags.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  assign gpio_dat_o = stable_q;
  assign irq_pend_o = pend_q;
  assign irq_o      = |pend_q;

endmodule

// File: tb/tb_gpio_in_conditioner.sv
// Directed self-checking bench for gpio_in_conditioner with the default
// parameters (26 pins, 2 sync stages, 16-cycle debounce).

module tb_gpio_in_conditioner;

  localparam int NUM_PINS = 26;
  localparam logic [NUM_PINS-1:0] ALL_ONES = '1;

  logic                clk_i;
  logic                rst_ni;
  logic [NUM_PINS-1:0] pad_i;
  logic [NUM_PINS-1:0] deb_en_i;
  logic [NUM_PINS-1:0] rise_en_i;
  logic [NUM_PINS-1:0] fall_en_i;
  logic [NUM_PINS-1:0] irq_clr_i;
  logic [NUM_PINS-1:0] gpio_dat_o;
  logic [NUM_PINS-1:0] irq_pend_o;
  logic                irq_o;

  int checks = 0;
  int errors = 0;

  gpio_in_conditioner #(
    .NUM_PINS(NUM_PINS),
    .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(16)
  ) dut (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .pad_i(pad_i),
    .deb_en_i(deb_en_i),
    .rise_en_i(rise_en_i),
    .fall_en_i(fall_en_i),
    .irq_clr_i(irq_clr_i),
    .gpio_dat_o(gpio_dat_o),
    .irq_pend_o(irq_pend_o),
    .irq_o(irq_o)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Let n rising edges pass, then settle 1 time unit past the last one.
  task automatic waitEdges(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_ni    = 1'b0;
    pad_i     = ALL_ONES;
    deb_en_i  = '0;
    rise_en_i = '0;
    fall_en_i = '0;
    irq_clr_i = '0;

    // Reset held with pads high: everything stays at zero.
    waitEdges(2);
    checkOutput("reset_dat", 32'(gpio_dat_o), 32'h0);
    checkOutput("reset_pend", 32'(irq_pend_o), 32'h0);
    checkOutput("reset_irq", 32'(irq_o), 32'h0);

    // Release in bypass mode: output appears on the third edge.
    rst_ni = 1'b1;
    waitEdges(2);
    checkOutput("bypass_edge2", 32'(gpio_dat_o), 32'h0);
    waitEdges(1);
    checkOutput("bypass_edge3", 32'(gpio_dat_o), 32'(ALL_ONES));
    checkOutput("bypass_irq", 32'(irq_o), 32'h0);

    // Return all pads low.
    pad_i = '0;
    waitEdges(4);
    checkOutput("all_low", 32'(gpio_dat_o), 32'h0);
    checkOutput("all_low_pend", 32'(irq_pend_o), 32'h0);

    // Debounce accept on pin 0: rises on edge 18, not edge 17.
    deb_en_i[0] = 1'b1;
    pad_i[0]    = 1'b1;
    waitEdges(17);
    checkOutput("deb_edge17", 32'(gpio_dat_o[0]), 32'h0);
    waitEdges(1);
    checkOutput("deb_edge18", 32'(gpio_dat_o[0]), 32'h1);
    checkOutput("deb_no_pend", 32'(irq_pend_o), 32'h0);

    // Glitch reject on pin 5: 15 high samples never reach the output.
    deb_en_i[5] = 1'b1;
    pad_i[5]    = 1'b1;
    for (int k = 0; k < 15; k++) begin
      waitEdges(1);
      checkOutput("glitch_high", 32'(gpio_dat_o[5]), 32'h0);
    end
    pad_i[5] = 1'b0;
    for (int k = 0; k < 20; k++) begin
      waitEdges(1);
      checkOutput("glitch_after", 32'(gpio_dat_o[5]), 32'h0);
    end
    pad_i[5] = 1'b1;
    waitEdges(17);
    checkOutput("glitch_hold17", 32'(gpio_dat_o[5]), 32'h0);
    waitEdges(1);
    checkOutput("glitch_hold18", 32'(gpio_dat_o[5]), 32'h1);

    // Rising-edge interrupt on pin 3 in bypass mode.
    rise_en_i[3] = 1'b1;
    pad_i[3]     = 1'b1;
    waitEdges(2);
    checkOutput("rise_before", 32'(irq_pend_o), 32'h0);
    waitEdges(1);
    checkOutput("rise_dat", 32'(gpio_dat_o[3]), 32'h1);
    checkOutput("rise_pend", 32'(irq_pend_o), 32'h8);
    checkOutput("rise_irq", 32'(irq_o), 32'h1);

    // Falling edge with fall_en off: no change to pending.
    pad_i[3] = 1'b0;
    waitEdges(3);
    checkOutput("fall_dat", 32'(gpio_dat_o[3]), 32'h0);
    checkOutput("fall_pend", 32'(irq_pend_o), 32'h8);

    // Clear pulse removes pin 3 pending and irq.
    irq_clr_i[3] = 1'b1;
    waitEdges(1);
    irq_clr_i[3] = 1'b0;
    checkOutput("clr_pend", 32'(irq_pend_o), 32'h0);
    checkOutput("clr_irq", 32'(irq_o), 32'h0);

    // Clear coinciding with the pin 7 rising transition: set wins.
    rise_en_i[7] = 1'b1;
    pad_i[7]     = 1'b1;
    waitEdges(2);
    irq_clr_i[7] = 1'b1;
    waitEdges(1);
    irq_clr_i[7] = 1'b0;
    checkOutput("collide_pend", 32'(irq_pend_o), 32'h80);
    irq_clr_i[7] = 1'b1;
    waitEdges(1);
    irq_clr_i[7] = 1'b0;
    checkOutput("collide_clr", 32'(irq_pend_o), 32'h0);

    // Build pend = 0x3 on pins 0 and 1 through bypass rising edges.
    deb_en_i[0] = 1'b0;
    pad_i[1:0]  = 2'b00;
    waitEdges(4);
    rise_en_i[1:0] = 2'b11;
    pad_i[1:0]     = 2'b11;
    waitEdges(3);
    checkOutput("pend_03", 32'(irq_pend_o), 32'h3);

    // Start a debounce count on pin 5, then reset between edges.
    pad_i[5] = 1'b0;
    waitEdges(5);
    checkOutput("mid_count_dat5", 32'(gpio_dat_o[5]), 32'h1);
    #2;
    rst_ni = 1'b0;
    #1;
    checkOutput("async_dat", 32'(gpio_dat_o), 32'h0);
    checkOutput("async_pend", 32'(irq_pend_o), 32'h0);
    checkOutput("async_irq", 32'(irq_o), 32'h0);

    // Release with edge enables off: no stale pend, outputs re-sync.
    rise_en_i = '0;
    fall_en_i = '0;
    deb_en_i  = '0;
    waitEdges(2);
    rst_ni = 1'b1;
    waitEdges(3);
    checkOutput("rerelease_dat", 32'(gpio_dat_o), 32'(pad_i));
    waitEdges(2);
    checkOutput("rerelease_pend", 32'(irq_pend_o), 32'h0);
    checkOutput("rerelease_irq", 32'(irq_o), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
